stream_rr_arb_fifo_has_flush: RTL and testbench
===============================================

# stream_rr_arb_fifo_has_flush

Round-robin arbiter that shares one flushable pipe-through stream FIFO between NUM_REQ requester streams. Each accepted beat is tagged with its source index and queued; the consumer drains tagged beats in order. Sits in front of shared back-end queues, e.g. per-warp issue or memory-request ports merging into one FIFO, and obeys the same pipeline flush as the FIFO.

## Interface
- NUM_REQ, 4: number of requesters, ≥2.
- DATA_WIDTH, 32: payload bits per beat.
- FIFO_DEPTH, 4: queue entries, ≥1.
- SRC_W, derived = clog2(NUM_REQ): source-tag width, not overridable.

- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush: clears queue, arbiter state.
- req_valid_i  in  NUM_REQ  per-requester valid.
- req_ready_o  out  NUM_REQ  per-requester ready; one-hot or zero.
- req_data_i  in  NUM_REQ*DATA_WIDTH  payloads, requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- req_last_i  in  NUM_REQ  burst-end marker; used only with lock feature.
- out_valid_o  out  1  queue head valid.
- out_ready_i  in  1  consumer ready.
- out_data_o  out  DATA_WIDTH  head payload.
- out_src_o  out  SRC_W  head source index.

## Operation
- Eligible set = req_valid_i (restricted to lock owner when locked, see Configuration).
- Grant: first eligible index at or after rr_ptr, searching upward with wrap NUM_REQ-1 → 0. Combinational.
- w_ready = !full | out_ready_i (pipe-through). req_ready_o[g] = grant[g] & w_ready & !flush; all other bits 0.
- Push when any req_valid_i[g] & req_ready_o[g]; entry = {g, req_data_i[g]}.
- On push: rr_ptr ← (g == NUM_REQ-1) ? 0 : g+1. No push → rr_ptr holds.
- Pop when out_ready_i & !empty. out_valid_o = !empty & !flush.
- flush: queue emptied, rr_ptr ← 0, lock state ← IDLE at that edge; no push, out_valid_o=0 during flush cycle. A pop handshake is not counted during flush (out_valid_o low).
- Reset: rr_ptr=0, queue empty, lock IDLE; out_valid_o=0, req_ready_o=all ones masked by grant → 0 since nothing granted without valid; out_data_o/out_src_o don't-care.

## Timing
- Enqueue-to-output latency 1 cycle: beat pushed at edge N visible on out_valid_o after edge N.
- Full queue with out_ready_i=1: push and pop same cycle, occupancy unchanged, no bubble.
- Empty queue: no combinational bypass; out_valid_o low in push cycle.
- Full with out_ready_i=0: req_ready_o all 0, rr_ptr holds, requester payloads must stay stable (stream rule: valid never drops without handshake, except on flush).
- Throughput: one beat per cycle aggregate; fair RR across continuously valid requesters.
- Reset mid-burst or mid-queue: all state cleared asynchronously; no beats preserved.

## Configuration
- STREAM_ARB_LOCK_EN defined: burst lock. States IDLE, LOCKED(owner). IDLE→LOCKED(g) on push with req_last_i[g]=0; LOCKED→IDLE on push from owner with req_last_i[owner]=1; in LOCKED only owner eligible, other requesters wait even if owner invalid. rr_ptr advances only on the LOCKED→IDLE push (or single-beat IDLE push with last=1). flush/reset → IDLE.
- Undefined: req_last_i ignored, per-beat round-robin, no lock state.

## Structure
- Shared package stream_arb_pkg: clog2-based SRC_W function, lock state encoding (ARB_IDLE, ARB_LOCKED).
- Sub-module: fifo_with_flush, width DATA_WIDTH+SRC_W, depth FIFO_DEPTH; rr pointer, grant search, lock FSM in this block.

## Test plan
- Reset, all 4 req_valid_i=1, out_ready_i=1 → pushes grant 0,1,2,3,0…; out_src_o sequence 0,1,2,3 starting 1 cycle after first push.
- Depth 4, out_ready_i=0, req 2 valid with data 0xA0..0xA3 → 4 pushes then req_ready_o=0; raise out_ready_i → 0xA0 pops and 0xA4 pushes same cycle.
- Only req 3 and 1 valid, rr_ptr=2 → grant 3, then 1, then 3.
- Queue holds 3 beats, assert flush one cycle with req 0 valid → out_valid_o=0, req_ready_o=0 that cycle; next cycle queue empty, rr_ptr=0, req 0 granted.
- STREAM_ARB_LOCK_EN: req 1 sends 3 beats (last on third) while req 0,2 valid → out_src_o 1,1,1, then 2; undefined build → 1,2,0 interleave.
- rst_n low while locked and queue full → out_valid_o=0 immediately, lock IDLE, after release first grant from index 0.

Source files
------------

// File: rtl/stream_arb_pkg.sv
// Shared definitions for the round-robin stream arbiter in front of the
// flushable FIFO: source-tag width helper and burst-lock state encoding.
package stream_arb_pkg;

    // Lock state of the arbiter (only used when the burst lock is built in).
    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Number of bits needed to encode n distinct source indices.
    function automatic int calc_src_w(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            w = ((32'sd1 <<< i) < n) ? (i + 1) : w;
        end
        return w;
    endfunction

endpackage

// File: rtl/fifo_with_flush.sv
// Flushable synchronous FIFO used as the shared queue behind the arbiter.
// Flush empties the queue at the clock edge and suppresses push/pop.
module fifo_with_flush #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_s;
    logic             pop_s;

    // Advance a pointer with wrap at DEPTH-1 (DEPTH need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : (p + {{(PTR_W-1){1'b0}}, 1'b1});
    endfunction

    assign empty_o = (count_r == {CNT_W{1'b0}});
    assign full_o  = (count_r == CNT_W'(DEPTH));
    assign push_s  = push_i & ~flush;
    assign pop_s   = pop_i & ~empty_o & ~flush;
    assign rdata_o = mem_r[rd_ptr_r];

    // Storage write; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wdata_i;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointer and occupancy bookkeeping, cleared by reset or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/stream_rr_arb_fifo_has_flush.sv
// Round-robin arbiter merging NUM_REQ streams into one flushable FIFO.
// Beats are tagged with their source index. Optional burst lock is built
// in when STREAM_ARB_LOCK_EN is defined; otherwise req_last_i is ignored.
module stream_rr_arb_fifo_has_flush
    import stream_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]              req_last_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [DATA_WIDTH-1:0]           out_data_o,
    output logic [calc_src_w(NUM_REQ)-1:0]  out_src_o
);

    localparam int SRC_W   = calc_src_w(NUM_REQ);
    localparam int ENTRY_W = DATA_WIDTH + SRC_W;

    logic [SRC_W-1:0]      rr_ptr_r;
    logic [NUM_REQ-1:0]    eligible_s;
    logic                  grant_vld_s;
    logic [SRC_W-1:0]      grant_idx_s;
    logic [DATA_WIDTH-1:0] grant_data_s;
    logic [SRC_W-1:0]      rr_next_s;
    logic                  w_ready_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  empty_s;
    logic                  full_s;
    logic [ENTRY_W-1:0]    head_s;

    // First eligible requester at or after rr_ptr, wrapping to index 0.
    always_comb begin
        int  idx;
        logic hit;
        grant_vld_s  = 1'b0;
        grant_idx_s  = {SRC_W{1'b0}};
        grant_data_s = {DATA_WIDTH{1'b0}};
        idx          = 0;
        hit          = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx          = int'(rr_ptr_r) + k;
            idx          = (idx >= NUM_REQ) ? (idx - NUM_REQ) : idx;
            hit          = eligible_s[idx] & ~grant_vld_s;
            grant_idx_s  = hit ? SRC_W'(idx) : grant_idx_s;
            grant_data_s = hit ? req_data_i[idx*DATA_WIDTH +: DATA_WIDTH] : grant_data_s;
            grant_vld_s  = grant_vld_s | hit;
        end
    end

    assign w_ready_s = ~full_s | out_ready_i;
    assign rr_next_s = (grant_idx_s == SRC_W'(NUM_REQ - 1)) ? {SRC_W{1'b0}}
                                                            : (grant_idx_s + {{(SRC_W-1){1'b0}}, 1'b1});

    // Ready goes only to the granted requester while the queue can accept.
    always_comb begin
        req_ready_o = {NUM_REQ{1'b0}};
        if (grant_vld_s && w_ready_s && !flush) begin
            req_ready_o[grant_idx_s] = 1'b1;
        end else begin
            req_ready_o = {NUM_REQ{1'b0}};
        end
    end

    assign push_s = |(req_valid_i & req_ready_o);
    assign pop_s  = out_ready_i & ~empty_s;

`ifdef STREAM_ARB_LOCK_EN
    arb_state_e       lock_state_r;
    logic [SRC_W-1:0] owner_r;
    logic             grant_last_s;

    assign eligible_s   = (lock_state_r == ARB_LOCKED)
                        ? (req_valid_i & ({{(NUM_REQ-1){1'b0}}, 1'b1} << owner_r))
                        : req_valid_i;
    assign grant_last_s = req_last_i[grant_idx_s];

    // Burst lock FSM; the round-robin pointer moves only when a burst ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_state_r <= ARB_IDLE;
            owner_r      <= {SRC_W{1'b0}};
            rr_ptr_r     <= {SRC_W{1'b0}};
        end else if (flush) begin
            lock_state_r <= ARB_IDLE;
            owner_r      <= {SRC_W{1'b0}};
            rr_ptr_r     <= {SRC_W{1'b0}};
        end else if (push_s) begin
            case (lock_state_r)
                ARB_IDLE: begin
                    if (grant_last_s) begin
                        rr_ptr_r <= rr_next_s;
                    end else begin
                        lock_state_r <= ARB_LOCKED;
                        owner_r      <= grant_idx_s;
                    end
                end
                ARB_LOCKED: begin
                    if (grant_last_s) begin
                        lock_state_r <= ARB_IDLE;
                        rr_ptr_r     <= rr_next_s;
                    end else begin
                        lock_state_r <= ARB_LOCKED;
                    end
                end
                default: begin
                    lock_state_r <= ARB_IDLE;
                end
            endcase
        end else begin
            lock_state_r <= lock_state_r;
        end
    end
`else
    logic unused_last_s;
    assign unused_last_s = ^req_last_i;
    assign eligible_s    = req_valid_i;

    // Per-beat round robin: pointer moves past the winner on every push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= {SRC_W{1'b0}};
        end else if (flush) begin
            rr_ptr_r <= {SRC_W{1'b0}};
        end else if (push_s) begin
            rr_ptr_r <= rr_next_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
`endif

    fifo_with_flush #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .push_i  (push_s),
        .wdata_i ({grant_idx_s, grant_data_s}),
        .pop_i   (pop_s),
        .rdata_o (head_s),
        .empty_o (empty_s),
        .full_o  (full_s)
    );

    assign out_valid_o = ~empty_s & ~flush;
    assign out_src_o   = head_s[ENTRY_W-1 -: SRC_W];
    assign out_data_o  = head_s[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_stream_rr_arb_fifo_has_flush.sv
// Directed, table-driven bench for stream_rr_arb_fifo_has_flush
// (NUM_REQ=4, DATA_WIDTH=32, FIFO_DEPTH=4).
module tb_stream_rr_arb_fifo_has_flush;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_data;
    logic [3:0]   req_last;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_src;

    int tests_run;
    int tests_failed;

    stream_rr_arb_fifo_has_flush #(
        .NUM_REQ    (4),
        .DATA_WIDTH (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_src_o   (out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic        ordy;
        logic        flsh;
        logic [3:0]  exp_ready;
        logic        exp_ov;
        logic [1:0]  exp_src;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int          sent1;
    logic [1:0]  prev_grant;
    logic [3:0]  exp_rdy_seq [4];
    logic [1:0]  exp_gnt_seq [4];

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = 4'h0;
        req_last  = 4'hF;
        out_ready = 1'b0;
        req_data  = {32'h13, 32'h12, 32'h11, 32'h10};

        // valid, out_ready, flush, exp ready, exp out_valid, exp src, exp data
        vecs[0]  = '{4'hF, 1'b1, 1'b0, 4'b0001, 1'b0, 2'd0, 32'h00};
        vecs[1]  = '{4'hF, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd0, 32'h10};
        vecs[2]  = '{4'hF, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd1, 32'h11};
        vecs[3]  = '{4'hF, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd2, 32'h12};
        vecs[4]  = '{4'hF, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd3, 32'h13};
        vecs[5]  = '{4'hF, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd0, 32'h10};
        vecs[6]  = '{4'h0, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 32'h11};
        vecs[7]  = '{4'h1, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd1, 32'h11};
        vecs[8]  = '{4'h1, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd1, 32'h11};
        vecs[9]  = '{4'h3, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h00};
        vecs[10] = '{4'h3, 1'b0, 1'b0, 4'b0001, 1'b0, 2'd0, 32'h00};
        vecs[11] = '{4'h0, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 32'h10};
        vecs[12] = '{4'h0, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd0, 32'h10};
        vecs[13] = '{4'h2, 1'b1, 1'b0, 4'b0010, 1'b0, 2'd0, 32'h00};
        vecs[14] = '{4'hA, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd1, 32'h11};
        vecs[15] = '{4'hA, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd3, 32'h13};
        vecs[16] = '{4'hA, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd1, 32'h11};
        vecs[17] = '{4'h0, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd3, 32'h13};
        vecs[18] = '{4'h0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 32'h00};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_req_ready", {28'd0, req_ready}, 32'd0);
        rst_n = 1'b1;

        // Table: round robin, flush, sparse requesters
        for (int i = 0; i < 19; i++) begin
            req_valid = vecs[i].valid;
            out_ready = vecs[i].ordy;
            flush     = vecs[i].flsh;
            #1;
            check($sformatf("v%0d_ready", i), {28'd0, req_ready}, {28'd0, vecs[i].exp_ready});
            check($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].exp_ov});
            if (vecs[i].exp_ov) begin
                check($sformatf("v%0d_src", i), {30'd0, out_src}, {30'd0, vecs[i].exp_src});
                check($sformatf("v%0d_data", i), out_data, vecs[i].exp_data);
            end
            @(negedge clk);
        end
        flush = 1'b0;

        // Fill depth 4 from requester 2 with out_ready low
        out_ready = 1'b0;
        req_valid = 4'b0100;
        for (int j = 0; j < 4; j++) begin
            req_data[64 +: 32] = 32'hA0 + 32'(j);
            #1;
            check($sformatf("fill%0d_ready", j), {28'd0, req_ready}, 32'h4);
            @(negedge clk);
        end
        req_data[64 +: 32] = 32'hA4;
        for (int j = 0; j < 2; j++) begin
            #1;
            check("full_ready", {28'd0, req_ready}, 32'h0);
            check("full_head", out_data, 32'hA0);
            check("full_src", {30'd0, out_src}, 32'd2);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("full_pipe_ready", {28'd0, req_ready}, 32'h4);
        check("full_pipe_head", out_data, 32'hA0);
        @(negedge clk);
        req_valid = 4'h0;
        for (int j = 1; j <= 4; j++) begin
            #1;
            check($sformatf("drain%0d_valid", j), {31'd0, out_valid}, 32'd1);
            check($sformatf("drain%0d_data", j), out_data, 32'hA0 + 32'(j));
            @(negedge clk);
        end
        #1;
        check("drain_empty", {31'd0, out_valid}, 32'd0);

        // Burst: prime rr_ptr to 1 with one beat from requester 0
        req_valid = 4'b0001;
        #1;
        check("prime_ready", {28'd0, req_ready}, 32'h1);
        @(negedge clk);
        prev_grant = 2'd0;
`ifdef STREAM_ARB_LOCK_EN
        exp_rdy_seq = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};
        exp_gnt_seq = '{2'd1, 2'd1, 2'd1, 2'd2};
`else
        exp_rdy_seq = '{4'b0010, 4'b0100, 4'b0001, 4'b0010};
        exp_gnt_seq = '{2'd1, 2'd2, 2'd0, 2'd1};
`endif
        sent1 = 0;
        for (int c = 0; c < 4; c++) begin
            req_valid = {1'b0, 1'b1, (sent1 < 3), 1'b1};
            req_last  = {2'b11, (sent1 == 2), 1'b1};
            #1;
            check($sformatf("burst%0d_ready", c), {28'd0, req_ready}, {28'd0, exp_rdy_seq[c]});
            check($sformatf("burst%0d_src", c), {30'd0, out_src}, {30'd0, prev_grant});
            if (req_ready[1]) sent1++;
            prev_grant = exp_gnt_seq[c];
            @(negedge clk);
        end
        req_valid = 4'h0;
        req_last  = 4'hF;
        #1;
        check("burst_tail_src", {30'd0, out_src}, {30'd0, prev_grant});
        @(negedge clk);
        #1;
        check("burst_empty", {31'd0, out_valid}, 32'd0);

        // Fill queue, then asynchronous reset mid-cycle
        out_ready = 1'b0;
        req_valid = 4'hF;
        repeat (4) @(negedge clk);
        #1;
        check("prereset_full_ready", {28'd0, req_ready}, 32'h0);
        check("prereset_valid", {31'd0, out_valid}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("postreset_ready", {28'd0, req_ready}, 32'h1);
        check("postreset_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        #1;
        check("postreset_src", {30'd0, out_src}, 32'd0);
        check("postreset_data", out_data, 32'h10);
        req_valid = 4'h0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
